// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_write_arbiter_pkg
//   Shared sizes and requester indices for the register-file write arbiter,
//   plus a one-hot decode helper used by the pending-write scoreboard.
package regfile_write_arbiter_pkg;

  localparam int SIZE_WORD = 16;
  localparam int SIZE_REG  = 4;
  localparam int REG_AW    = 2;

  localparam int REQ_ALU   = 0;
  localparam int REQ_LOAD  = 1;

  function automatic logic [SIZE_REG-1:0] reg_onehot(input logic [REG_AW-1:0] idx);
    logic [SIZE_REG-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// rr_arb2
//   Combinational 2-way round-robin grant.
//   valid[1:0]  : request vector (index = requester)
//   last_grant  : requester that won the most recent completed handshake
//   hold        : suppresses all grants
//   grant[1:0]  : one-hot (or zero) grant
module rr_arb2 (
  input  logic       hold,
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    grant = 2'b00;
    if (!hold) begin
      grant[0] = valid[0] & (~valid[1] | last_grant);
      grant[1] = valid[1] & (~valid[0] | ~last_grant);
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the register file's single write port between the ALU (req0) and
//   load (req1) writeback paths with round-robin arbitration, registers the
//   winning write (latency 1), and tracks per-register pending writes.
//   Ports:
//     clk, reset_n               : clock, async active-low reset
//     hold                       : blocks new grants
//     req{0,1}_valid/reg/data    : writeback requests, req{0,1}_ready = grant
//     rsv_valid/rsv_reg/rsv_ready: decode destination reservation
//     busy                       : pending-write bit per register
//     PVSWriteEn/RegWrite        : write pulse, one per grant
//     writeReg/writeData         : registered write address/data
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 hold,
  input  logic                 req0_valid,
  input  logic [REG_AW-1:0]    req0_reg,
  input  logic [SIZE_WORD-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [REG_AW-1:0]    req1_reg,
  input  logic [SIZE_WORD-1:0] req1_data,
  output logic                 req1_ready,
  input  logic                 rsv_valid,
  input  logic [REG_AW-1:0]    rsv_reg,
  output logic                 rsv_ready,
  output logic [SIZE_REG-1:0]  busy,
  output logic                 PVSWriteEn,
  output logic                 RegWrite,
  output logic [REG_AW-1:0]    writeReg,
  output logic [SIZE_WORD-1:0] writeData
);

  logic [1:0]           grant;
  logic                 hs_any;
  logic [REG_AW-1:0]    win_reg;
  logic [SIZE_WORD-1:0] win_data;
  logic [SIZE_REG-1:0]  clear_vec, set_vec;

  logic                 last_grant_q, last_grant_d;
  logic [SIZE_REG-1:0]  busy_q, busy_d;
  logic                 wen_q, wen_d;
  logic [REG_AW-1:0]    wreg_q, wreg_d;
  logic [SIZE_WORD-1:0] wdata_q, wdata_d;

  rr_arb2 u_arb (
    .hold       (hold),
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign req0_ready = grant[REQ_ALU];
  assign req1_ready = grant[REQ_LOAD];

  always_comb begin
    hs_any   = (req0_valid & grant[REQ_ALU]) | (req1_valid & grant[REQ_LOAD]);
    win_reg  = grant[REQ_LOAD] ? req1_reg  : req0_reg;
    win_data = grant[REQ_LOAD] ? req1_data : req0_data;

    clear_vec = hs_any ? reg_onehot(win_reg) : '0;
    // A register retiring this cycle may be re-reserved immediately.
    rsv_ready = ~busy_q[rsv_reg] | clear_vec[rsv_reg];
    set_vec   = (rsv_valid & rsv_ready) ? reg_onehot(rsv_reg) : '0;
    // Set after clear so a same-cycle reservation wins.
    busy_d    = (busy_q & ~clear_vec) | set_vec;

    last_grant_d = last_grant_q;
    if (hs_any) last_grant_d = grant[REQ_LOAD];

    wen_d   = hs_any;
    wreg_d  = hs_any ? win_reg  : wreg_q;
    wdata_d = hs_any ? win_data : wdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      busy_q       <= '0;
      wen_q        <= 1'b0;
      wreg_q       <= '0;
      wdata_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      wen_q        <= wen_d;
      wreg_q       <= wreg_d;
      wdata_q      <= wdata_d;
    end
  end

  assign busy       = busy_q;
  assign PVSWriteEn = wen_q;
  assign RegWrite   = wen_q;
  assign writeReg   = wreg_q;
  assign writeData  = wdata_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        hold;
  logic        req0_valid, req1_valid, rsv_valid;
  logic [1:0]  req0_reg, req1_reg, rsv_reg;
  logic [15:0] req0_data, req1_data;
  logic        req0_ready, req1_ready, rsv_ready;
  logic [3:0]  busy;
  logic        PVSWriteEn, RegWrite;
  logic [1:0]  writeReg;
  logic [15:0] writeData;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .hold       (hold),
    .req0_valid (req0_valid),
    .req0_reg   (req0_reg),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_reg   (req1_reg),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rsv_valid  (rsv_valid),
    .rsv_reg    (rsv_reg),
    .rsv_ready  (rsv_ready),
    .busy       (busy),
    .PVSWriteEn (PVSWriteEn),
    .RegWrite   (RegWrite),
    .writeReg   (writeReg),
    .writeData  (writeData)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    hold = 0; req0_valid = 0; req1_valid = 0; rsv_valid = 0;
    req0_reg = 0; req1_reg = 0; rsv_reg = 0; req0_data = 0; req1_data = 0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pwe",   PVSWriteEn, 0);
    chk("rst_rw",    RegWrite,   0);
    chk("rst_wreg",  writeReg,   0);
    chk("rst_wdata", writeData,  0);
    chk("rst_busy",  busy,       0);
    reset_n = 1'b1;

    // Single ALU write
    req0_valid = 1; req0_reg = 2; req0_data = 16'h1234;
    #1;
    chk("s_rdy0", req0_ready, 1);
    chk("s_rdy1", req1_ready, 0);
    tick();
    req0_valid = 0;
    chk("s_pwe",   PVSWriteEn, 1);
    chk("s_rw",    RegWrite,   1);
    chk("s_wreg",  writeReg,   2);
    chk("s_wdata", writeData,  16'h1234);
    tick();
    chk("s_pwe_off", PVSWriteEn, 0);
    chk("s_rw_off",  RegWrite,   0);
    chk("s_wreg_hold", writeReg, 2);

    // Round-robin alternation from reset state
    do_reset();
    req0_valid = 1; req0_reg = 1; req0_data = 16'hAAAA;
    req1_valid = 1; req1_reg = 3; req1_data = 16'h5555;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_rdy0", req0_ready, (k % 2 == 0) ? 1 : 0);
      chk("rr_rdy1", req1_ready, (k % 2 == 0) ? 0 : 1);
      tick();
      if (k == 3) begin req0_valid = 0; req1_valid = 0; end
      chk("rr_pwe",   PVSWriteEn, 1);
      chk("rr_wreg",  writeReg,  (k % 2 == 0) ? 1 : 3);
      chk("rr_wdata", writeData, (k % 2 == 0) ? 16'hAAAA : 16'h5555);
    end
    tick();
    chk("rr_pwe_off", PVSWriteEn, 0);

    // hold blocks grants, release favours requester 0 after reset
    do_reset();
    hold = 1; req0_valid = 1; req1_valid = 1;
    #1;
    chk("h_rdy0", req0_ready, 0);
    chk("h_rdy1", req1_ready, 0);
    tick();
    chk("h_pwe", PVSWriteEn, 0);
    hold = 0;
    #1;
    chk("h_rel_rdy0", req0_ready, 1);
    chk("h_rel_rdy1", req1_ready, 0);
    tick();
    req0_valid = 0; req1_valid = 0;
    chk("h_rel_pwe",  PVSWriteEn, 1);
    chk("h_rel_wreg", writeReg,   1);
    tick();

    // Scoreboard reservations
    do_reset();
    rsv_valid = 1; rsv_reg = 2;
    #1;
    chk("sb_rsv1", rsv_ready, 1);
    tick();
    chk("sb_busy1", busy, 4'b0100);
    #1;
    chk("sb_rsv2", rsv_ready, 0);
    tick();
    chk("sb_busy2", busy, 4'b0100);
    req1_valid = 1; req1_reg = 2; req1_data = 16'hBEEF;
    #1;
    chk("sb_rdy1", req1_ready, 1);
    chk("sb_rsv3", rsv_ready, 1);
    tick();
    req1_valid = 0; rsv_valid = 0;
    chk("sb_busy3", busy, 4'b0100);
    chk("sb_wdata", writeData, 16'hBEEF);
    tick();

    // Asynchronous reset with a pulse registered and busy = 1010
    do_reset();
    rsv_valid = 1; rsv_reg = 1;
    tick();
    rsv_reg = 3;
    tick();
    rsv_valid = 0;
    req0_valid = 1; req0_reg = 0; req0_data = 16'h0077;
    tick();
    req0_valid = 0;
    chk("ar_pwe_pre",  PVSWriteEn, 1);
    chk("ar_busy_pre", busy, 4'b1010);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_pwe",  PVSWriteEn, 0);
    chk("ar_rw",   RegWrite,   0);
    chk("ar_busy", busy,       0);
    #2;
    reset_n = 1'b1;

    // Same destination from both requesters
    tick();
    req0_valid = 1; req0_reg = 0; req0_data = 16'h1111;
    req1_valid = 1; req1_reg = 0; req1_data = 16'h2222;
    #1;
    chk("sd_rdy0", req0_ready, 1);
    chk("sd_rdy1", req1_ready, 0);
    tick();
    req0_valid = 0;
    chk("sd_pwe1",   PVSWriteEn, 1);
    chk("sd_wdata1", writeData,  16'h1111);
    #1;
    chk("sd_rdy1b", req1_ready, 1);
    tick();
    req1_valid = 0;
    chk("sd_pwe2",   PVSWriteEn, 1);
    chk("sd_wreg2",  writeReg,   0);
    chk("sd_wdata2", writeData,  16'h2222);
    tick();
    chk("sd_pwe_off", PVSWriteEn, 0);
    chk("sd_final",   writeData,  16'h2222);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: requester 0 (ALU result) and requester 1 (memory load data).
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Drives the register file's PVSWriteEn, RegWrite, writeReg and writeData from a registered output stage.
- Keeps a per-register pending-write scoreboard so decode can detect and stall on outstanding writes.

Parameters:
- SIZE_WORD, 16, data word width.
- SIZE_REG, 4, number of architectural registers.
- REG_AW, 2, register index width (log2 SIZE_REG).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- hold  in  1  pipeline freeze; blocks new grants while 1.
- req0_valid  in  1  ALU writeback request.
- req0_reg  in  REG_AW  ALU destination register.
- req0_data  in  SIZE_WORD  ALU result.
- req0_ready  out  1  ALU request accepted this cycle.
- req1_valid  in  1  load writeback request.
- req1_reg  in  REG_AW  load destination register.
- req1_data  in  SIZE_WORD  load data.
- req1_ready  out  1  load request accepted this cycle.
- rsv_valid  in  1  decode reserves a destination register.
- rsv_reg  in  REG_AW  register being reserved.
- rsv_ready  out  1  reservation accepted this cycle.
- busy  out  SIZE_REG  per-register pending-write bits.
- PVSWriteEn  out  1  register-file write enable (state commit).
- RegWrite  out  1  register-file write request.
- writeReg  out  REG_AW  write address.
- writeData  out  SIZE_WORD  write data.

Behaviour:
- Reset (async assert, sync release) sets:
  - PVSWriteEn=0, RegWrite=0, writeReg=0, writeData=0.
  - busy=0.
  - last_grant=1, so requester 0 wins the first tie.
- Grant logic is combinational in the same cycle:
  - If hold=1, grant nobody.
  - Otherwise, if exactly one requester is valid, grant it.
  - If both are valid, grant the requester that is not last_grant.
  - req*_ready = that requester's grant; the handshake completes when valid&ready.
- last_grant updates only on a completed handshake.
- Requesters hold valid, reg and data stable until ready. The arbiter does not check this.
- Output stage, latency 1:
  - On a granted cycle, the next edge loads writeReg/writeData from the winner and sets PVSWriteEn=1 and RegWrite=1.
  - With no grant, the next edge sets PVSWriteEn=0 and RegWrite=0; writeReg/writeData hold their last value.
  - Each grant produces exactly one write pulse; back-to-back grants give consecutive pulses.
- hold affects new grants only. A pulse already registered still appears in the following cycle.
- Scoreboard:
  - clear_vec: bit of the granted requester's reg set on a handshake.
  - set_vec: bit of rsv_reg set when rsv_valid&rsv_ready.
  - busy_next = (busy & ~clear_vec) | set_vec, so a set wins over a clear on the same register in the same cycle.
  - rsv_ready = ~busy[rsv_reg] | clear_vec[rsv_reg]. A reservation of a register being retired in the same cycle is accepted.
  - A handshake to a register whose busy bit is 0 is legal. busy stays 0 and the write still occurs.
- Same destination from both requesters in one cycle: only one is granted; the loser stays pending and is granted next cycle unless hold=1.
- Reset mid-operation drops any registered write pulse, clears busy, and restores last_grant=1.

Decomposition:
- Shared package/header holds SIZE_WORD, SIZE_REG, REG_AW and the requester index constants REQ_ALU=0 and REQ_LOAD=1.
- One sub-module: rr_arb2, the combinational 2-way round-robin grant given the valid vector, last_grant and hold.
- The scoreboard and output register stay in the top module.

Test Plan:
- Reset, then req0 (reg 2, 0x1234) only → req0_ready=1 in that cycle; next cycle PVSWriteEn=RegWrite=1, writeReg=2, writeData=0x1234; the cycle after, both 0.
- Both valid for 4 cycles (req0 reg1/0xAAAA, req1 reg3/0x5555, each re-presented after accept) → grants in order 0,1,0,1; four consecutive write pulses alternating reg 1 and reg 3.
- hold=1 with both valid → both readys 0 and no pulse; release hold → requester 0 granted first (last_grant=1 after reset).
- rsv reg 2 → busy=0100; rsv reg 2 again → rsv_ready=0; req1 writes reg 2 while rsv reg 2 in the same cycle → rsv_ready=1 and busy stays 0100.
- Assert reset_n=0 asynchronously while a pulse is registered and busy=1010 → PVSWriteEn=0 and busy=0000 immediately, without waiting for a clock edge.
- req0 and req1 both target reg 0 → one write per cycle over two cycles; the second write's data is the final value on writeData.
